// File: rtl/asym_fifo_ctrl_w8r32.sv
// Byte-in / word-out FIFO controller: 8-bit write port, 32-bit little-endian read port.
// Optional sticky overflow/underflow flags are enabled by defining ASYM_FIFO_ERR_FLAGS_EN.
module asym_fifo_ctrl_w8r32 #(
   parameter int WORDS_LOG2 = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  wr_valid,
   input  logic [7:0]            wr_data,
   output logic                  wr_ready,
   output logic                  rd_valid,
   output logic [31:0]           rd_data,
   input  logic                  rd_ready,
   output logic [WORDS_LOG2+2:0] level,
   output logic                  empty
`ifdef ASYM_FIFO_ERR_FLAGS_EN
   ,
   output logic                  overflow,
   output logic                  underflow
`endif
);

   localparam int LW    = WORDS_LOG2 + 3;
   localparam int BYTES = 1 << (WORDS_LOG2 + 2);
   localparam logic [LW-1:0] CAP  = LW'(BYTES);
   localparam logic [LW-1:0] FOUR = LW'(4);

   logic [7:0]            mem [BYTES];
   logic [WORDS_LOG2+1:0] wr_ptr;
   logic [WORDS_LOG2-1:0] rd_ptr;
   logic                  fetch_pending;
   logic [31:0]           fetch_word;
   logic                  wr_acc;
   logic                  fetch;
   logic [LW-1:0]         level_nxt;

   assign wr_ready = (level != CAP) && !flush;
   assign wr_acc   = wr_valid && wr_ready;
   // A new fetch may only issue when the output register will be free at the load edge.
   assign fetch    = (level >= FOUR) && !fetch_pending && (!rd_valid || rd_ready) && !flush;
   assign empty    = (level < FOUR) && !rd_valid && !fetch_pending;

   always_comb begin
      level_nxt = level;
      if (wr_acc) level_nxt = level_nxt + LW'(1);
      if (fetch)  level_nxt = level_nxt - FOUR;
   end

   // The write address is always a free slot, so it never aliases the word being fetched.
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr] <= wr_data;
      if (fetch)
         fetch_word <= {mem[{rd_ptr, 2'b11}], mem[{rd_ptr, 2'b10}],
                        mem[{rd_ptr, 2'b01}], mem[{rd_ptr, 2'b00}]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         level         <= '0;
         fetch_pending <= 1'b0;
         rd_valid      <= 1'b0;
         rd_data       <= '0;
      end else if (flush) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         level         <= '0;
         fetch_pending <= 1'b0;
         rd_valid      <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (fetch)  rd_ptr <= rd_ptr + 1'b1;
         level         <= level_nxt;
         fetch_pending <= fetch;
         if (fetch_pending) begin
            rd_data  <= fetch_word;
            rd_valid <= 1'b1;
         end else if (rd_valid && rd_ready) begin
            rd_valid <= 1'b0;
         end
      end
   end

`ifdef ASYM_FIFO_ERR_FLAGS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (flush) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_valid && !wr_ready) overflow  <= 1'b1;
         if (rd_ready && !rd_valid) underflow <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_asym_fifo_ctrl_w8r32.sv
// Randomized + directed bench for asym_fifo_ctrl_w8r32 against a byte-queue reference model.
module tb_asym_fifo_ctrl_w8r32;
   localparam int WL  = 6;
   localparam int CAP = 256;

   logic          clk = 1'b0;
   logic          rst, flush, wr_valid, rd_ready;
   logic [7:0]    wr_data;
   logic          wr_ready, rd_valid, empty;
   logic [31:0]   rd_data;
   logic [WL+2:0] level;
`ifdef ASYM_FIFO_ERR_FLAGS_EN
   logic          overflow, underflow;
`endif

   asym_fifo_ctrl_w8r32 #(.WORDS_LOG2(WL)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
      .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
      .level(level), .empty(empty)
`ifdef ASYM_FIFO_ERR_FLAGS_EN
      , .overflow(overflow), .underflow(underflow)
`endif
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int words_rx = 0;
   int acc_cnt = 0;

   // Model: bytes in memory, one in-flight word, one output word.
   byte unsigned mq[$];
   byte unsigned sq[$];
   bit           m_pend, m_vld, m_of, m_uf;
   logic [31:0]  m_pword, m_data;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic bit m_empty();
      return (mq.size() < 4) && !m_vld && !m_pend;
   endfunction

   task automatic compare();
      chk("rd_valid", rd_valid, m_vld);
      chk("level", 32'(level), mq.size());
      chk("empty", empty, m_empty());
      if (m_vld) chk("rd_data", rd_data, m_data);
`ifdef ASYM_FIFO_ERR_FLAGS_EN
      chk("overflow", overflow, m_of);
      chk("underflow", underflow, m_uf);
`endif
   endtask

   task automatic m_reset();
      mq.delete(); sq.delete();
      m_pend = 0; m_vld = 0; m_of = 0; m_uf = 0;
      m_data = '0; m_pword = '0;
   endtask

   // Drive one cycle of inputs, advance the model, check after the edge.
   task automatic step(input bit wv, input logic [7:0] wd, input bit rr, input bit fl);
      bit          wrdy, fet;
      logic [31:0] w;
      wr_valid = wv; wr_data = wd; rd_ready = rr; flush = fl;
      #1;
      wrdy = (mq.size() != CAP) && !fl;
      chk("wr_ready", wr_ready, wrdy);
      if (!fl && rd_valid && rr) begin
         if (sq.size() < 4) chk("sb_avail", sq.size(), 4);
         else begin
            w = {sq[3], sq[2], sq[1], sq[0]};
            repeat (4) void'(sq.pop_front());
            chk("sb_order", rd_data, w);
            words_rx++;
         end
      end
      if (fl) begin
         m_of = 0; m_uf = 0;
      end else begin
         if (wv && !wrdy) m_of = 1;
         if (rr && !m_vld) m_uf = 1;
      end
      if (fl) begin
         mq.delete(); sq.delete();
         m_pend = 0; m_vld = 0;
      end else begin
         fet = (mq.size() >= 4) && !m_pend && (!m_vld || rr);
         if (m_pend) begin
            m_vld = 1; m_data = m_pword;
         end else if (m_vld && rr) m_vld = 0;
         m_pend = fet;
         if (fet) begin
            m_pword = {mq[3], mq[2], mq[1], mq[0]};
            repeat (4) void'(mq.pop_front());
         end
         if (wv && wrdy) begin
            mq.push_back(wd); sq.push_back(wd); acc_cnt++;
         end
      end
      @(posedge clk); #1;
      compare();
   endtask

   // Asynchronous reset asserted between clock edges.
   task automatic do_reset();
      #2; rst = 1'b1; #1;
      chk("rst_rd_valid", rd_valid, 1'b0);
      chk("rst_level", 32'(level), 0);
      chk("rst_empty", empty, 1'b1);
      chk("rst_rd_data", rd_data, 32'h0);
      m_reset();
      @(posedge clk); #1;
      rst = 1'b0; wr_valid = 0; rd_ready = 0; flush = 0;
      #1;
      chk("rst_wr_ready", wr_ready, 1'b1);
   endtask

   task automatic drain();
      int n = 0;
      while (!(mq.size() == 0 && !m_vld && !m_pend) && n < 3000) begin
         step(0, 8'h00, 1'($urandom_range(0, 1)), 0);
         n++;
      end
      chk("drain_done", n < 3000, 1'b1);
   endtask

   initial begin
      int i;
      bit hit;
      rst = 1'b1; flush = 0; wr_valid = 0; rd_ready = 0; wr_data = '0;
      m_reset();
      #1;
      chk("init_rd_valid", rd_valid, 1'b0);
      chk("init_level", 32'(level), 0);
      chk("init_empty", empty, 1'b1);
      chk("init_rd_data", rd_data, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("init_wr_ready", wr_ready, 1'b1);

      // Single word, read side always ready.
      step(1, 8'h11, 1, 0); step(1, 8'h22, 1, 0);
      step(1, 8'h33, 1, 0); step(1, 8'h44, 1, 0);
      chk("t31_level4", 32'(level), 4);
      step(0, 8'h00, 1, 0);
      chk("t31_not_yet", rd_valid, 1'b0);
      step(0, 8'h00, 1, 0);
      chk("t31_valid", rd_valid, 1'b1);
      chk("t31_word", rd_data, 32'h44332211);
      step(0, 8'h00, 1, 0);
      chk("t31_empty", empty, 1'b1);

      // Partial word stays put until completed.
      step(1, 8'hAA, 1, 0); step(1, 8'hBB, 1, 0); step(1, 8'hCC, 1, 0);
      chk("t32_level3", 32'(level), 3);
      repeat (20) step(0, 8'h00, 1, 0);
      chk("t32_still_3", 32'(level), 3);
      chk("t32_no_word", rd_valid, 1'b0);
      step(1, 8'hDD, 0, 0);
      hit = 0;
      for (i = 0; i < 6 && !hit; i++) begin
         step(0, 8'h00, 0, 0);
         hit = rd_valid;
      end
      chk("t32_valid", rd_valid, 1'b1);
      chk("t32_word", rd_data, 32'hDDCCBBAA);
      step(0, 8'h00, 1, 0);

      // Fill to capacity with the reader stalled.
      do_reset();
      for (i = 0; i < 256; i++) step(1, 8'(i), 0, 0);
      chk("t33_level252", 32'(level), 252);
      for (i = 0; i < 4; i++) step(1, 8'(i + 256), 0, 0);
      chk("t33_level256", 32'(level), 256);
      chk("t33_full", wr_ready, 1'b0);
      step(1, 8'hEE, 0, 0);
`ifdef ASYM_FIFO_ERR_FLAGS_EN
      chk("t33_overflow", overflow, 1'b1);
`endif

      // Stalled output holds.
      repeat (10) step(0, 8'h00, 0, 0);
      chk("t34_valid", rd_valid, 1'b1);
      chk("t34_word", rd_data, 32'h03020100);
      chk("t34_level", 32'(level), 256);
      drain();

      // Random stream across several pointer wraps.
      do_reset();
      words_rx = 0; acc_cnt = 0;
      i = 0;
      while (acc_cnt < 1024 && i < 20000) begin
         step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) != 0), 0);
         i++;
      end
      chk("t35_accepted", acc_cnt, 1024);
      drain();
      chk("t35_words", words_rx, 256);
      chk("t35_leftover", sq.size(), 0);

      // Flush in the would-be fetch-issue cycle.
      do_reset();
      for (i = 0; i < 4; i++) step(1, 8'(i + 8'h50), 1, 0);
      step(0, 8'h00, 1, 1);
      chk("t36_fl_valid", rd_valid, 1'b0);
      chk("t36_fl_level", 32'(level), 0);
      chk("t36_fl_empty", empty, 1'b1);
      repeat (5) step(0, 8'h00, 1, 0);
      chk("t36_fl_stale", rd_valid, 1'b0);

      // Flush with a fetch in flight.
      for (i = 0; i < 4; i++) step(1, 8'(i + 8'h60), 0, 0);
      step(0, 8'h00, 0, 0);
      chk("t36_pend_model", m_pend, 1'b1);
      step(0, 8'h00, 0, 1);
      chk("t36_pf_valid", rd_valid, 1'b0);
      chk("t36_pf_empty", empty, 1'b1);
      repeat (4) step(0, 8'h00, 1, 0);
      chk("t36_pf_stale", rd_valid, 1'b0);

      // Reset mid-stream, aimed at a cycle with a fetch in flight.
      repeat (30) step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 0);
      i = 0;
      while (!m_pend && i < 50) begin
         step(1, 8'($urandom), 1, 0);
         i++;
      end
      chk("t36_found_pend", m_pend, 1'b1);
      do_reset();
      repeat (5) step(0, 8'h00, 1, 0);
      chk("t36_rst_stale", rd_valid, 1'b0);
      chk("t36_rst_empty", empty, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/asym_fifo_ctrl_w8r32.md
ASYM_FIFO_CTRL_W8R32 -- requirements
Module: asym_fifo_ctrl_w8r32

Interface
REQ-001 The block SHALL have parameter WORDS_LOG2, default 6, log2 of 32-bit word capacity (byte capacity 2^(WORDS_LOG2+2), 256 by default).
REQ-002 The block SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port flush  input  1  synchronous clear of all FIFO state.
REQ-005 The block SHALL have port wr_valid  input  1  byte write request.
REQ-006 The block SHALL have port wr_data  input  8  write byte.
REQ-007 The block SHALL have port wr_ready  output  1  byte accepted when wr_valid && wr_ready.
REQ-008 The block SHALL have port rd_valid  output  1  rd_data holds a valid word.
REQ-009 The block SHALL have port rd_data  output  32  word; byte0 (first written) in [7:0], byte3 in [31:24].
REQ-010 The block SHALL have port rd_ready  input  1  word consumed when rd_valid && rd_ready.
REQ-011 The block SHALL have port level  output  WORDS_LOG2+3  bytes stored in memory and not yet fetched.
REQ-012 The block SHALL have port empty  output  1  level<4 && !rd_valid && !fetch_pending.

Function
REQ-013 Storage SHALL be an internal byte array with one 8-bit write port and one synchronous 32-bit read port reading bytes {rd_ptr,2'b00}..{rd_ptr,2'b11}.
REQ-014 wr_ready SHALL equal (level != capacity) && !flush; an accepted byte SHALL be written at wr_ptr, and wr_ptr SHALL increment modulo capacity.
REQ-015 A fetch SHALL issue in a cycle when level>=4, fetch_pending==0, (rd_valid==0 || rd_ready==1), and flush==0.
REQ-016 An issued fetch SHALL register the addressed word, SHALL set fetch_pending, SHALL increment rd_ptr modulo word capacity, and SHALL subtract 4 from level at the same edge.
REQ-017 The cycle after a fetch, rd_data SHALL load the fetched word, rd_valid SHALL be set, and fetch_pending SHALL clear; issue-to-rd_valid latency is 2 edges, peak throughput one word per 2 cycles.
REQ-018 A handshake on rd_valid && rd_ready with no word loading that edge SHALL clear rd_valid; rd_data SHALL hold its value until the next load.
REQ-019 A write and a fetch in the same cycle SHALL update level by +1-4; a fetch frees memory at issue, so a same-cycle write may target the freed locations only after level reflects it.
REQ-020 Partial words (level 1..3) SHALL stay in memory, with rd_valid low, until completed.
REQ-021 flush SHALL clear wr_ptr, rd_ptr, level, fetch_pending, and rd_valid at the next edge and SHALL discard any in-flight fetch; memory contents are don't-care.
REQ-022 Pointer wrap SHALL be seamless: byte capacity-1 followed by byte 0 forms no word boundary error, since capacity is a multiple of 4.

Reset
REQ-023 rst SHALL asynchronously force wr_ptr=0, rd_ptr=0, level=0, fetch_pending=0, rd_valid=0, rd_data=0, and, where present, overflow=0 and underflow=0.
REQ-024 After rst deasserts, empty SHALL be 1 and wr_ready SHALL be 1; memory SHALL need no reset.
REQ-025 rst asserted mid-fetch SHALL abandon the fetch; no rd_valid SHALL follow.

Configuration
REQ-026 With ASYM_FIFO_ERR_FLAGS_EN defined, the block SHALL add outputs overflow (1) and underflow (1).
REQ-027 overflow SHALL set sticky on wr_valid && !wr_ready && !flush.
REQ-028 underflow SHALL set sticky on rd_ready && !rd_valid && !empty-cause-free... i.e. rd_ready while rd_valid==0.
REQ-029 overflow and underflow SHALL clear only on rst or flush.
REQ-030 Without ASYM_FIFO_ERR_FLAGS_EN, these ports and their logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-031 Write 0x11,0x22,0x33,0x44 with rd_ready=1 -> rd_valid 2 edges after level reaches 4, rd_data=0x44332211, then empty=1.
REQ-032 Write 3 bytes only -> level=3, rd_valid stays 0 for 20 cycles; the 4th byte then produces a word.
REQ-033 Fill 256 bytes with rd_ready=0 -> after the first word is fetched, level=252, and it reaches 256 after 4 more writes with wr_ready=0; the extra write sets overflow (macro on).
REQ-034 Hold rd_ready=0 with rd_valid=1 -> rd_data stable, no further fetch, level unchanged.
REQ-035 Stream 1024 bytes through with random wr_valid/rd_ready -> words match in order across pointer wrap; no loss or duplication.
REQ-036 Assert flush in the fetch-issue cycle, then separately assert rst mid-stream -> next cycle rd_valid=0, level=0, empty=1, and no stale word appears.
